uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART link: serial line in, byte handshake and status out.
// master is the receiver; slave is the consumer that drives the line and acknowledges bytes.
interface uart_rx_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. Samples each bit at mid-bit and
// presents received bytes through a level valid / ack handshake.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [31:0] BitLim       = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HalfLim      = 32'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        sync1_q, sync2_q;
  logic        rx_s;
  logic        load;

  // Two-flop synchronizer; both stages reset to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLim) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLim) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitLim) begin
          cnt_d = '0;
          if (rx_s) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitIdle: begin
        // Hold off until the line is released so a break is not decoded as 0x00 frames.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new byte outranks a same-cycle ack: valid stays set and no overrun is flagged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (bus.rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !bus.rx_ack) begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: good frames, glitch, framing error,
// overrun, ack/load collision and mid-frame reset.
module tb_uart_rx;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   fe_count;

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_FREQ(50_000_000),
    .BAUD    (5_000_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame_err is a one-cycle pulse, so each pulse is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (u_if.frame_err === 1'b1) fe_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u_if.rx     = 1'b1;
      u_if.rx_ack = 1'b0;
    end
  endtask

  // One 100-clock frame; ack_cycle >= 0 raises rx_ack for that single clock of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_cycle);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      u_if.rx     = bits[c / 10];
      u_if.rx_ack = (c == ack_cycle);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    u_if.rx_ack = 1'b1;
    @(negedge clk);
    u_if.rx_ack = 1'b0;
  endtask

  int fe_base;

  initial begin
    checks      = 0;
    failures    = 0;
    fe_count    = 0;
    rst         = 1'b0;
    u_if.rx     = 1'b1;
    u_if.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, u_if.rx_data}, 32'h00);
    check("rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    check("rst_ovr", {31'd0, u_if.overrun}, 32'd0);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    rst = 1'b1;
    idle(5);

    // Single good byte
    fe_base = fe_count;
    send_frame(8'hA5, 1'b1, -1);
    check("a5_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check("a5_data", {24'd0, u_if.rx_data}, 32'hA5);
    check("a5_busy", {31'd0, u_if.busy}, 32'd0);
    idle(5);
    check("a5_ferr", fe_count - fe_base, 32'd0);
    ack();
    check("a5_ack_valid", {31'd0, u_if.rx_valid}, 32'd0);
    idle(5);

    // Three-clock glitch is rejected as a false start
    fe_base = fe_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u_if.rx = 1'b0;
    end
    idle(20);
    check("glitch_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check("glitch_busy", {31'd0, u_if.busy}, 32'd0);
    check("glitch_ferr", fe_count - fe_base, 32'd0);
    send_frame(8'h3C, 1'b1, -1);
    check("3c_data", {24'd0, u_if.rx_data}, 32'h3C);
    check("3c_valid", {31'd0, u_if.rx_valid}, 32'd1);
    ack();
    idle(5);

    // Framing error followed by a held-low break
    fe_base = fe_count;
    send_frame(8'h55, 1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      u_if.rx = 1'b0;
    end
    check("brk_busy", {31'd0, u_if.busy}, 32'd1);
    check("brk_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check("brk_data", {24'd0, u_if.rx_data}, 32'h3C);
    idle(10);
    check("brk_ferr_pulses", fe_count - fe_base, 32'd1);
    check("brk_idle_busy", {31'd0, u_if.busy}, 32'd0);
    send_frame(8'h81, 1'b1, -1);
    check("81_data", {24'd0, u_if.rx_data}, 32'h81);
    check("81_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check("81_ferr", fe_count - fe_base, 32'd1);
    ack();
    idle(5);

    // Back-to-back frames without ack
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'hFE, 1'b1, -1);
    check("b2b_data", {24'd0, u_if.rx_data}, 32'hFE);
    check("b2b_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check("b2b_ovr", {31'd0, u_if.overrun}, 32'd1);
    ack();
    check("b2b_ack_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check("b2b_ack_ovr", {31'd0, u_if.overrun}, 32'd0);
    idle(5);

    // Ack in the same clock the second byte loads (load edge is clock 98 of the frame)
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 97);
    idle(2);
    check("coll_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check("coll_data", {24'd0, u_if.rx_data}, 32'h22);
    check("coll_ovr", {31'd0, u_if.overrun}, 32'd0);

    // Asynchronous reset in the middle of the data bits of 0xFF
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      u_if.rx = (c < 10) ? 1'b0 : 1'b1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, u_if.rx_data}, 32'h00);
    check("mid_rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("mid_rst_ovr", {31'd0, u_if.overrun}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(60);
    check("post_rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("post_rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    send_frame(8'h42, 1'b1, -1);
    check("42_data", {24'd0, u_if.rx_data}, 32'h42);
    check("42_valid", {31'd0, u_if.rx_valid}, 32'd1);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
